// File: rtl/lc3_int_pkg.sv
// rtl/lc3_int_pkg.sv - shared types and default vectors for the LC-3 interrupt controller
package lc3_int_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    VMUX_DEV  = 2'b00,
    VMUX_PRIV = 2'b01,
    VMUX_OPC  = 2'b10,
    VMUX_RSVD = 2'b11
  } vmux_e;

  localparam logic [7:0] DEF_VEC_BASE = 8'h02;
  localparam logic [7:0] DEF_PRIV_VEC = 8'h00;
  localparam logic [7:0] DEF_OPC_VEC  = 8'h01;

endpackage

// File: rtl/int_prio_ctl_if.sv
// rtl/int_prio_ctl_if.sv - control-FSM / vector-register side of the interrupt controller
interface int_prio_ctl_if #(
  parameter int PRI_W = 3
);

  logic [1:0]       VectorMUX;
  logic             LD_Vector;
  logic [7:0]       Vector;
  logic             INT;
  logic [PRI_W-1:0] INT_Priority;
  logic [2:0]       int_src;

  modport master (
    output VectorMUX, LD_Vector,
    input  Vector, INT, INT_Priority, int_src
  );

  modport slave (
    input  VectorMUX, LD_Vector,
    output Vector, INT, INT_Priority, int_src
  );

endinterface

// File: rtl/int_prio_arb.sv
// rtl/int_prio_arb.sv - picks the highest-priority pending source above cur_pri
module int_prio_arb #(
  parameter int NUM_SRC = 4,
  parameter int PRI_W   = 3
) (
  input  logic [NUM_SRC-1:0]       pending,
  input  logic [NUM_SRC*PRI_W-1:0] src_pri,
  input  logic [PRI_W-1:0]         cur_pri,
  output logic                     valid,
  output logic [2:0]               idx,
  output logic [PRI_W-1:0]         pri
);

  // Ascending scan with strict compare keeps ties on the lowest index.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pri   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending[i] && (src_pri[i*PRI_W +: PRI_W] > cur_pri) &&
          (!valid || (src_pri[i*PRI_W +: PRI_W] > pri))) begin
        valid = 1'b1;
        idx   = 3'(i);
        pri   = src_pri[i*PRI_W +: PRI_W];
      end
    end
  end

endmodule

// File: rtl/int_prio_ctl.sv
// rtl/int_prio_ctl.sv - NUM_SRC-way LC-3 interrupt controller with vector register
module int_prio_ctl
  import lc3_int_pkg::*;
#(
  parameter int               NUM_SRC   = 4,
  parameter int               PRI_W     = 3,
  parameter logic [7:0]       VEC_BASE  = DEF_VEC_BASE,
  parameter logic [7:0]       PRIV_VEC  = DEF_PRIV_VEC,
  parameter logic [7:0]       OPC_VEC   = DEF_OPC_VEC,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       src_ready,
  input  logic [NUM_SRC-1:0]       src_ie,
  input  logic [NUM_SRC*PRI_W-1:0] src_pri,
  input  logic [PRI_W-1:0]         cur_pri,
  int_prio_ctl_if.slave            bus
);

  logic [NUM_SRC-1:0] req, req_q, pending;
  state_e             state, state_nxt;
  logic [2:0]         lat_idx, lat_idx_nxt;
  logic [PRI_W-1:0]   lat_pri, lat_pri_nxt;
  logic               win_valid, lat_ok, ack;
  logic [2:0]         win_idx;
  logic [PRI_W-1:0]   win_pri;
  logic [7:0]         vector_q;

  assign req = src_ready & src_ie;
  assign ack = bus.LD_Vector && (bus.VectorMUX == VMUX_DEV) && (state == REQ);

  // Edge sources: a new rise in the acknowledge cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q   <= '0;
      pending <= '0;
    end else begin
      req_q <= req;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!EDGE_MASK[i])
          pending[i] <= req[i];
        else if (req[i] && !req_q[i])
          pending[i] <= 1'b1;
        else if (!src_ie[i] || (ack && (lat_idx == 3'(i))))
          pending[i] <= 1'b0;
      end
    end
  end

  int_prio_arb #(.NUM_SRC(NUM_SRC), .PRI_W(PRI_W)) u_arb (
    .pending (pending),
    .src_pri (src_pri),
    .cur_pri (cur_pri),
    .valid   (win_valid),
    .idx     (win_idx),
    .pri     (win_pri)
  );

  always_comb begin
    lat_ok = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (lat_idx == 3'(i))
        lat_ok = pending[i] && (src_pri[i*PRI_W +: PRI_W] > cur_pri);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_idx <= '0;
      lat_pri <= '0;
    end else begin
      state   <= state_nxt;
      lat_idx <= lat_idx_nxt;
      lat_pri <= lat_pri_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lat_idx_nxt = lat_idx;
    lat_pri_nxt = lat_pri;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_nxt   = REQ;
          lat_idx_nxt = win_idx;
          lat_pri_nxt = win_pri;
        end
      end
      REQ: begin
        if (ack) begin
          state_nxt = IDLE;
        end else if (lat_ok) begin
          if (win_valid && (win_pri > lat_pri)) begin
            lat_idx_nxt = win_idx;
            lat_pri_nxt = win_pri;
          end
        end else if (win_valid) begin
          lat_idx_nxt = win_idx;
          lat_pri_nxt = win_pri;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.INT          = (state == REQ);
    bus.INT_Priority = (state == REQ) ? lat_pri : '0;
    bus.int_src      = (state == REQ) ? lat_idx : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vector_q <= 8'h00;
    end else if (bus.LD_Vector) begin
      case (bus.VectorMUX)
        VMUX_DEV:  if (state == REQ) vector_q <= VEC_BASE + {5'b00000, lat_idx};
        VMUX_PRIV: vector_q <= PRIV_VEC;
        VMUX_OPC:  vector_q <= OPC_VEC;
        default:   vector_q <= vector_q;
      endcase
    end
  end

  assign bus.Vector = vector_q;

endmodule
